// File: rtl/send_sched_pkg.sv
// send_sched_pkg
// Shared widths and state encoding for the send packet scheduler.
//   ADDR_W        : width of the start RAM address buses
//   STAT_W        : width of the per-channel send statistics counters
//   sched_state_t : scheduler FSM state (IDLE, RUN)
package send_sched_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/send_pulse_gen.sv
// send_pulse_gen
// One transmit channel: a fixed-length cmd_send pulse, its start address register
// and an optional count of pulses issued.
// Build option: SEND_SCHED_STATS_EN builds send_count; otherwise it is tied to 0.
// Ports:
//   clk_50_pll     in  : clock
//   main_reset     in  : asynchronous active-high reset
//   fire           in  : start a pulse on this edge
//   abort          in  : kill any pulse in flight (wins over fire)
//   cmd_send       out : registered send command
//   start_ram_addr out : address, loaded with ADDR on the pulse's rising edge
//   send_count     out : pulses issued, wraps at 16'hFFFF
module send_pulse_gen
    import send_sched_pkg::*;
#(
    parameter int unsigned        PULSE_LEN = 3,
    parameter logic [ADDR_W-1:0]  ADDR      = 25'd1
) (
    input  logic              clk_50_pll,
    input  logic              main_reset,
    input  logic              fire,
    input  logic              abort,
    output logic              cmd_send,
    output logic [ADDR_W-1:0] start_ram_addr,
    output logic [STAT_W-1:0] send_count
);

    // Remaining high cycles after the current one.
    localparam logic [3:0] LEN_LOAD = 4'(PULSE_LEN - 1);

    logic              cmd_q;
    logic [3:0]        len_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            cmd_q  <= 1'b0;
            len_q  <= 4'd0;
            addr_q <= '0;
        end else if (abort) begin
            // Truncate the pulse; the address register keeps its value.
            cmd_q <= 1'b0;
            len_q <= 4'd0;
        end else if (fire) begin
            cmd_q  <= 1'b1;
            len_q  <= LEN_LOAD;
            addr_q <= ADDR;
        end else if (cmd_q) begin
            if (len_q == 4'd0) begin
                cmd_q <= 1'b0;
            end else begin
                len_q <= len_q - 4'd1;
            end
        end
    end

    assign cmd_send       = cmd_q;
    assign start_ram_addr = addr_q;

`ifdef SEND_SCHED_STATS_EN
    logic [STAT_W-1:0] count_q;

    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            count_q <= '0;
        end else if (fire && !abort) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign send_count = count_q;
`else
    assign send_count = '0;
`endif

endmodule

// File: rtl/send_packet_scheduler.sv
// send_packet_scheduler
// Periodic transmit-command scheduler for the two send_packet channels. Once the
// link is usable it runs a frame counter and fires channel 1 at PERIOD_1 and
// channel 2 at PERIOD_2; the frame wraps after PERIOD_2 + WRAP_GAP cycles.
// Build option: SEND_SCHED_STATS_EN enables send_count_1/2 (otherwise tied to 0).
// Ports:
//   clk_50_pll         in  : clock
//   main_reset         in  : asynchronous active-high reset
//   mac_inited         in  : MAC configuration complete
//   rx_ready           in  : PHY receive path ready
//   enable             in  : software run enable
//   cmd_send_1/2       out : per-channel send command pulses
//   start_ram_addr_1/2 out : per-channel start address
//   active             out : scheduler is in RUN
//   send_count_1/2     out : per-channel pulses issued
module send_packet_scheduler
    import send_sched_pkg::*;
#(
    parameter logic [31:0]        PERIOD_1  = 32'h000000FF,
    parameter logic [31:0]        PERIOD_2  = 32'h000001FF,
    parameter int unsigned        PULSE_LEN = 3,
    parameter int unsigned        WRAP_GAP  = 10,
    parameter logic [ADDR_W-1:0]  ADDR_1    = 25'd1,
    parameter logic [ADDR_W-1:0]  ADDR_2    = 25'd5
) (
    input  logic              clk_50_pll,
    input  logic              main_reset,
    input  logic              mac_inited,
    input  logic              rx_ready,
    input  logic              enable,
    output logic              cmd_send_1,
    output logic [ADDR_W-1:0] start_ram_addr_1,
    output logic              cmd_send_2,
    output logic [ADDR_W-1:0] start_ram_addr_2,
    output logic              active,
    output logic [STAT_W-1:0] send_count_1,
    output logic [STAT_W-1:0] send_count_2
);

    localparam logic [31:0] WRAP_AT = PERIOD_2 + WRAP_GAP;

    if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : gen_bad_pulse_len
        $error("send_packet_scheduler: PULSE_LEN must be in 1..15");
    end
    if (PERIOD_1 == 32'd0) begin : gen_bad_period_1
        $error("send_packet_scheduler: PERIOD_1 must be >= 1");
    end
    if (PERIOD_2 <= PERIOD_1 + PULSE_LEN) begin : gen_bad_period_2
        $error("send_packet_scheduler: PERIOD_2 must exceed PERIOD_1 + PULSE_LEN");
    end
    if (WRAP_GAP <= PULSE_LEN) begin : gen_bad_wrap_gap
        $error("send_packet_scheduler: WRAP_GAP must exceed PULSE_LEN");
    end

    sched_state_t state_q;
    logic [31:0]  cnt_q;
    logic [31:0]  cnt_inc;
    logic [31:0]  cnt_d;
    logic         link_ok;
    logic         fire_1;
    logic         fire_2;

    assign link_ok = mac_inited & rx_ready & enable;

    // cnt_q is 0 in IDLE, so cnt_d is 1 there and the same compare covers the
    // IDLE->RUN edge.
    always_comb begin
        cnt_inc = cnt_q + 32'd1;
        cnt_d   = (cnt_inc == WRAP_AT) ? 32'd0 : cnt_inc;
    end

    assign fire_1 = link_ok && (cnt_d == PERIOD_1);
    assign fire_2 = link_ok && (cnt_d == PERIOD_2);

    always_ff @(posedge clk_50_pll or posedge main_reset) begin
        if (main_reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
        end else if (!link_ok) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= RUN;
            cnt_q   <= cnt_d;
        end
    end

    assign active = (state_q == RUN);

    send_pulse_gen #(
        .PULSE_LEN (PULSE_LEN),
        .ADDR      (ADDR_1)
    ) u_chan_1 (
        .clk_50_pll     (clk_50_pll),
        .main_reset     (main_reset),
        .fire           (fire_1),
        .abort          (!link_ok),
        .cmd_send       (cmd_send_1),
        .start_ram_addr (start_ram_addr_1),
        .send_count     (send_count_1)
    );

    send_pulse_gen #(
        .PULSE_LEN (PULSE_LEN),
        .ADDR      (ADDR_2)
    ) u_chan_2 (
        .clk_50_pll     (clk_50_pll),
        .main_reset     (main_reset),
        .fire           (fire_2),
        .abort          (!link_ok),
        .cmd_send       (cmd_send_2),
        .start_ram_addr (start_ram_addr_2),
        .send_count     (send_count_2)
    );

endmodule

// File: doc/send_packet_scheduler.md
# send_packet_scheduler

Periodic transmit-command scheduler that drives the two `send_packet` control ports of the platform system design. It runs in the `clk_50_pll` domain and waits until the MAC is initialised and the PHY receive path is ready. It then issues fixed-length `cmd_send` pulses, each with a stable start RAM address, to channel 1 and then channel 2 on a repeating frame. It replaces the inline send counter in the SFP test top level and adds link-loss recovery and optional per-channel send statistics.

## Interface
Parameters:
- `PERIOD_1`, 32'h000000FF: counter value at which the channel-1 pulse starts.
- `PERIOD_2`, 32'h000001FF: counter value at which the channel-2 pulse starts.
- `PULSE_LEN`, 3: `cmd_send` high time in cycles; legal range 1..15.
- `WRAP_GAP`, 10: cycles after `PERIOD_2` before the counter wraps.
- `ADDR_1`, 25'd1: start RAM address for channel 1.
- `ADDR_2`, 25'd5: start RAM address for channel 2.

Ports:
- `clk_50_pll` in 1: clock.
- `main_reset` in 1: reset, asynchronous, active-high.
- `mac_inited` in 1: MAC configuration complete.
- `rx_ready` in 1: PHY reset controller receive ready.
- `enable` in 1: software run enable.
- `cmd_send_1` out 1: channel-1 send command.
- `start_ram_addr_1` out 25: channel-1 start address.
- `cmd_send_2` out 1: channel-2 send command.
- `start_ram_addr_2` out 25: channel-2 start address.
- `active` out 1: high while the scheduler is in RUN.
- `send_count_1` out 16: channel-1 pulses issued.
- `send_count_2` out 16: channel-2 pulses issued.

## Operation
- `link_ok = mac_inited & rx_ready & enable`. This is a combinational input qualifier.
- State machine, two states:
  - IDLE: `cnt` = 0, both `cmd_send` outputs low. Move to RUN on the first edge with `link_ok` = 1. `cnt` becomes 1 on that same edge.
  - RUN: `cnt` increments by 1 each cycle.
    - When the next value equals `PERIOD_2 + WRAP_GAP`, load 0 instead. `cnt` never holds that value.
    - On any edge with `link_ok` = 0: go to IDLE, clear `cnt`, drop both `cmd_send` outputs. Statistics are not cleared.
- Channel 1 pulse:
  - `cmd_send_1` goes high on the edge where `cnt` becomes `PERIOD_1`.
  - It goes low on the edge where `cnt` becomes `PERIOD_1 + PULSE_LEN`.
  - `start_ram_addr_1` is loaded with `ADDR_1` on the rising edge of the pulse. It is held until the next load and is never changed while `cmd_send_1` is high.
- Channel 2 pulse: same rules using `PERIOD_2` and `ADDR_2`.
- Arithmetic:
  - `cnt` is 32 bit.
  - Compare values are computed in 32 bit; parameters guarantee no overflow.
- Statistics counters:
  - Increment once per rising edge of the corresponding `cmd_send`.
  - Wrap from 16'hFFFF to 0.
- Elaboration checks (`$error` on violation):
  - `PERIOD_1 ≥ 1`.
  - `PERIOD_2 > PERIOD_1 + PULSE_LEN`.
  - `WRAP_GAP > PULSE_LEN`.
  - Together these make the two pulses never overlap, and stop a pulse from spanning a wrap.
- Link loss mid-pulse truncates the pulse. The address register keeps its value.

## Timing
- Reset values: `cnt` = 0, state IDLE, all outputs 0, both address outputs 25'd0.
- All outputs are registered. None are combinational from inputs.
- From `link_ok` rising to `cmd_send_1` high: `PERIOD_1` edges.
- Frame length: `PERIOD_2 + WRAP_GAP` cycles.
- From `link_ok` falling to all `cmd_send` outputs low: 1 edge.
- `main_reset` asserted mid-pulse clears everything asynchronously.

## Configuration
- `SEND_SCHED_STATS_EN` defined: `send_count_1` and `send_count_2` are implemented as described.
- Undefined: the counters are not built, and `send_count_1` and `send_count_2` are tied to 16'd0. The ports remain present.

## Structure
- Package `send_sched_pkg`:
  - `ADDR_W` = 25.
  - State enum `sched_state_t` {IDLE, RUN}.
  - `STAT_W` = 16.
- Sub-module `send_pulse_gen`, instantiated once per channel. It takes `fire`, `abort` and the address parameter, and produces `cmd_send`, the address register and the optional count. It contains a 4-bit length down-counter.
- The top contains the FSM, the frame counter and the compare logic.

## Test plan
Bench parameters for all scenarios: `PERIOD_1` = 16, `PERIOD_2` = 32, `PULSE_LEN` = 3, `WRAP_GAP` = 10.
- Reset, then `link_ok` = 1 at cycle 0:
  - `cmd_send_1` high cycles 16–18 with `start_ram_addr_1` = 1.
  - `cmd_send_2` high cycles 32–34 with address 5.
  - Pulses repeat every 42 cycles.
- Hold `mac_inited` = 0: outputs stay 0 and `active` = 0 indefinitely.
- Drop `rx_ready` at cycle 17:
  - `cmd_send_1` low at cycle 18, state IDLE.
  - On reassertion, the next pulse starts 16 edges later.
- Assert `main_reset` at cycle 33: all outputs 0 immediately (asynchronous).
- With `SEND_SCHED_STATS_EN`: after 5 frames, `send_count_1` = 5 and `send_count_2` = 5. Without it, both read 0.
- Elaborate with `PERIOD_2` = 18: `$error` raised.
